// File: rtl/imm_ext_pipe_if.sv
// Valid/ready channel pair for imm_ext_pipe: instruction words in, extended immediates out.
// The pipeline itself connects through the slave modport; the producer/consumer side uses master.
interface imm_ext_pipe_if #(
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_imm;
    logic [2:0]        out_fmt;
    logic              out_illegal;

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal
    );

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal
    );
endinterface

// File: rtl/imm_ext_pipe.sv
// Two-stage LEGv8 immediate extractor/extender with a saturating illegal-opcode counter.
// Optional MOVZ (IW) decoding is enabled by defining IMM_MOVZ_EN.
module imm_ext_pipe #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    imm_ext_pipe_if.slave    bus,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_D    = 3'd1,
        FMT_CB   = 3'd2,
        FMT_B    = 3'd3,
        FMT_I    = 3'd4,
        FMT_IW   = 3'd5
    } fmt_t;

    fmt_t              dec_fmt;
    logic              s1_valid;
    fmt_t              s1_fmt;
    logic [25:0]       s1_bits;
    logic              s2_valid;
    fmt_t              s2_fmt;
    logic [DATA_W-1:0] s2_imm;
    logic              s2_illegal;
    logic [DATA_W-1:0] ext_imm;
    logic              adv1;
    logic              adv2;
    logic              accept;

    // Ready flows backwards only through stage occupancy and out_ready, never from in_valid.
    assign adv2         = !s2_valid || bus.out_ready;
    assign adv1         = !s1_valid || adv2;
    assign bus.in_ready = adv1;
    assign accept       = bus.in_valid && adv1;

    always_comb begin
        dec_fmt = FMT_NONE;
        if (bus.in_instr[31:21] == 11'b11111000010 || bus.in_instr[31:21] == 11'b11111000000)
            dec_fmt = FMT_D;
        else if (bus.in_instr[31:25] == 7'b1011010)
            dec_fmt = FMT_CB;
        else if (bus.in_instr[31:26] == 6'b000101)
            dec_fmt = FMT_B;
        else if (bus.in_instr[31:22] == 10'b1001000100 || bus.in_instr[31:22] == 10'b1101000100)
            dec_fmt = FMT_I;
`ifdef IMM_MOVZ_EN
        // A narrow datapath cannot hold hw=2/3 shifts, so those words are rejected here.
        else if (bus.in_instr[31:23] == 9'b110100101 && !(DATA_W == 32 && bus.in_instr[22]))
            dec_fmt = FMT_IW;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_fmt   <= FMT_NONE;
            s1_bits  <= '0;
        end else if (adv1) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_fmt  <= dec_fmt;
                s1_bits <= bus.in_instr[25:0];
            end
        end
    end

    always_comb begin
        ext_imm = '0;
        case (s1_fmt)
            FMT_D:   ext_imm = {{(DATA_W-9){s1_bits[20]}}, s1_bits[20:12]};
            FMT_CB:  ext_imm = {{(DATA_W-19){s1_bits[23]}}, s1_bits[23:5]};
            FMT_B:   ext_imm = {{(DATA_W-26){s1_bits[25]}}, s1_bits[25:0]};
            FMT_I:   ext_imm = {{(DATA_W-12){1'b0}}, s1_bits[21:10]};
`ifdef IMM_MOVZ_EN
            FMT_IW:  ext_imm = DATA_W'(s1_bits[20:5]) << {s1_bits[22:21], 4'b0000};
`endif
            default: ext_imm = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid   <= 1'b0;
            s2_fmt     <= FMT_NONE;
            s2_imm     <= '0;
            s2_illegal <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_fmt     <= s1_fmt;
                s2_imm     <= ext_imm;
                s2_illegal <= (s1_fmt == FMT_NONE);
            end
        end
    end

    // Counted at accept time so a stalled illegal word is counted exactly once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            illegal_cnt <= '0;
        else if (accept && dec_fmt == FMT_NONE && illegal_cnt != {CNT_W{1'b1}})
            illegal_cnt <= illegal_cnt + CNT_W'(1);
    end

    assign bus.out_valid   = s2_valid;
    assign bus.out_imm     = s2_imm;
    assign bus.out_fmt     = s2_fmt;
    assign bus.out_illegal = s2_illegal;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe (DATA_W=64, CNT_W=16); expected MOVZ behaviour follows IMM_MOVZ_EN.
module tb_imm_ext_pipe;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [15:0] illegal_cnt;
    exp_t        sb[$];
    logic [15:0] exp_cnt;
    int          n_checks;
    int          n_fail;
    int          n_out;

    imm_ext_pipe_if #(.DATA_W(64)) bus ();

    imm_ext_pipe #(.DATA_W(64), .CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .illegal_cnt (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference decode written from the opcode table, independent of the RTL structure.
    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        logic signed [8:0]  s9;
        logic signed [18:0] s19;
        logic signed [25:0] s26;
        e.imm = 64'd0;
        e.fmt = 3'd0;
        e.ill = 1'b1;
        s9  = w[20:12];
        s19 = w[23:5];
        s26 = w[25:0];
        if (w[31:21] == 11'h7C2 || w[31:21] == 11'h7C0) begin
            e.fmt = 3'd1; e.ill = 1'b0; e.imm = 64'(s9);
        end else if (w[31:24] == 8'hB4 || w[31:24] == 8'hB5) begin
            e.fmt = 3'd2; e.ill = 1'b0; e.imm = 64'(s19);
        end else if (w[31:26] == 6'h05) begin
            e.fmt = 3'd3; e.ill = 1'b0; e.imm = 64'(s26);
        end else if (w[31:22] == 10'h244 || w[31:22] == 10'h344) begin
            e.fmt = 3'd4; e.ill = 1'b0; e.imm = 64'(w[21:10]);
        end
`ifdef IMM_MOVZ_EN
        else if (w[31:23] == 9'h1A5) begin
            e.fmt = 3'd5; e.ill = 1'b0; e.imm = 64'(w[20:5]) << (16 * int'(w[22:21]));
        end
`endif
        return e;
    endfunction

    // One clock cycle: drive at the falling edge, then sample, score and predict before the rising edge.
    task automatic apply_stimulus(input logic v, input logic [31:0] w, input logic r, output logic acc);
        exp_t e;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_instr  = w;
        bus.out_ready = r;
        #1;
        check_output("illegal_cnt", 64'(illegal_cnt), 64'(exp_cnt));
        if (bus.out_valid && r) begin
            if (sb.size() == 0) begin
                check_output("unexpected_output", 64'(bus.out_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                n_out++;
                check_output("out_imm", bus.out_imm, e.imm);
                check_output("out_fmt", 64'(bus.out_fmt), 64'(e.fmt));
                check_output("out_illegal", 64'(bus.out_illegal), 64'(e.ill));
            end
        end
        acc = v && bus.in_ready;
        if (acc) begin
            e = model(w);
            sb.push_back(e);
            if (e.ill && exp_cnt != 16'hFFFF) exp_cnt++;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input logic r);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 100) begin
            apply_stimulus(1'b1, w, r, acc);
            tries++;
        end
        if (!acc) check_output("send_timeout", 64'(acc), 64'd1);
    endtask

    task automatic drain();
        logic acc;
        int   n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            apply_stimulus(1'b0, 32'd0, 1'b1, acc);
            n++;
        end
        check_output("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        sb.delete();
        exp_cnt = 16'd0;
        reset = 1'b1;
    endtask

    initial begin
        logic        acc;
        logic        saw_stall;
        logic [31:0] w;
        logic [31:0] stream[5];
        int          idx;
        exp_t        tmp;

        n_checks = 0;
        n_fail   = 0;
        n_out    = 0;
        exp_cnt  = 16'd0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'd0;
        bus.out_ready = 1'b0;
        reset = 1'b0;
        #2;
        check_output("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_output("rst_out_imm", bus.out_imm, 64'd0);
        check_output("rst_out_fmt", 64'(bus.out_fmt), 64'd0);
        check_output("rst_out_illegal", 64'(bus.out_illegal), 64'd0);
        check_output("rst_cnt", 64'(illegal_cnt), 64'd0);
        do_reset();

        $display("[TB] directed vectors and latency");
        apply_stimulus(1'b1, 32'hF85FF000, 1'b1, acc);
        check_output("ldur_accept", 64'(acc), 64'd1);
        tmp = sb.pop_back();
        tmp.imm = 64'hFFFF_FFFF_FFFF_FFFF; tmp.fmt = 3'd1; tmp.ill = 1'b0;
        sb.push_back(tmp);
        apply_stimulus(1'b0, 32'd0, 1'b1, acc);
        check_output("lat_cycle1_valid", 64'(bus.out_valid), 64'd0);
        apply_stimulus(1'b0, 32'd0, 1'b1, acc);
        check_output("lat_cycle2_valid", 64'(bus.out_valid), 64'd1);
        check_output("lat_popped", 64'(sb.size()), 64'd0);

        send_word(32'hB4000300, 1'b1);
        tmp = sb.pop_back(); tmp.imm = 64'h18; tmp.fmt = 3'd2; tmp.ill = 1'b0; sb.push_back(tmp);
        send_word(32'hF81FE000, 1'b1);
        tmp = sb.pop_back(); tmp.imm = 64'hFFFF_FFFF_FFFF_FFFE; tmp.fmt = 3'd1; tmp.ill = 1'b0; sb.push_back(tmp);
        drain();

        $display("[TB] stalled stream of five words");
        stream = '{32'hF85FF000, 32'hB4000300, 32'h17FFFFFF, 32'h91002C00, 32'hD13FFC00};
        idx = 0;
        saw_stall = 1'b0;
        n_out = 0;
        for (int c = 0; c < 40 && (idx < 5 || sb.size() != 0); c++) begin
            apply_stimulus(idx < 5, (idx < 5) ? stream[idx] : 32'd0, !(c >= 3 && c <= 6), acc);
            if (idx < 5 && !bus.in_ready) saw_stall = 1'b1;
            if (acc) idx++;
            if (c == 5) check_output("stall_in_ready", 64'(bus.in_ready), 64'd0);
        end
        check_output("stall_seen", 64'(saw_stall), 64'd1);
        check_output("stream_outputs", 64'(n_out), 64'd5);
        check_output("stream_sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] random mix with backpressure");
        for (int k = 0; k < 150; k++) begin
            w = $urandom;
            case ($urandom_range(0, 6))
                0: w[31:21] = 11'h7C2;
                1: w[31:24] = 8'hB5;
                2: w[31:26] = 6'h05;
                3: w[31:22] = 10'h344;
                4: w[31:23] = 9'h1A5;
                default: ;
            endcase
            acc = 1'b0;
            for (int t = 0; t < 100 && !acc; t++)
                apply_stimulus(1'b1, w, $urandom_range(0, 3) != 0, acc);
            if (!acc) check_output("rand_send_timeout", 64'(acc), 64'd1);
        end
        drain();

        $display("[TB] illegal word and MOVZ");
        send_word(32'h00000000, 1'b1);
        tmp = sb.pop_back(); tmp.imm = 64'd0; tmp.fmt = 3'd0; tmp.ill = 1'b1; sb.push_back(tmp);
        drain();
        check_output("illegal_cnt_after_zero_word", 64'(illegal_cnt), 64'(exp_cnt));
        send_word(32'hD2E02460, 1'b1);
        tmp = sb.pop_back();
`ifdef IMM_MOVZ_EN
        tmp.imm = 64'h0123_0000_0000_0000; tmp.fmt = 3'd5; tmp.ill = 1'b0;
`else
        tmp.imm = 64'd0; tmp.fmt = 3'd0; tmp.ill = 1'b1;
`endif
        sb.push_back(tmp);
        drain();

        $display("[TB] reset with both stages full");
        send_word(32'h00000000, 1'b0);
        send_word(32'hB4000300, 1'b0);
        apply_stimulus(1'b0, 32'd0, 1'b0, acc);
        check_output("full_out_valid", 64'(bus.out_valid), 64'd1);
        check_output("full_in_ready", 64'(bus.in_ready), 64'd0);
        reset = 1'b0;
        #1;
        check_output("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_output("async_rst_cnt", 64'(illegal_cnt), 64'd0);
        sb.delete();
        exp_cnt = 16'd0;
        @(negedge clk);
        reset = 1'b1;
        apply_stimulus(1'b0, 32'd0, 1'b1, acc);
        check_output("post_rst_idle", 64'(bus.out_valid), 64'd0);
        send_word(32'h17FFFFFF, 1'b1);
        tmp = sb.pop_back(); tmp.imm = 64'hFFFF_FFFF_FFFF_FFFF; tmp.fmt = 3'd3; tmp.ill = 1'b0; sb.push_back(tmp);
        n_out = 0;
        drain();
        check_output("post_rst_single_output", 64'(n_out), 64'd1);

        $display("[TB] counter saturation");
        do_reset();
        for (int k = 0; k < 65536 + 3; k++)
            send_word(32'h00000000, 1'b1);
        drain();
        check_output("cnt_saturated", 64'(illegal_cnt), 64'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
